// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: per-bit 2-flop synchroniser, saturating debounce
// counter, and one-cycle rise/fall pulses aligned with the new stable value.

// One switch bit: sync, debounce, edge pulses.
module switch_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CW              = 24
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept
);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // Accept is combinational so the top can register CHANGED in the same edge
  // that RISE/FALL are registered.
  assign accept = (sync2 != stable) && (cnt == LAST);

  // Two plain flops, nothing between them, to tame metastability.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive mismatches; any agreement clears progress. The counter
  // stops at LAST, so it can never wrap.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// N independent lanes plus a single registered any-change pulse.
module switch_debouncer #(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CW              = 24
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [N-1:0] SWITCH_IN,
  output logic [N-1:0] SWITCH_OUT,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL,
  output logic         CHANGED
);
  logic [N-1:0] accept;

  for (genvar i = 0; i < N; i++) begin : g_lane
    switch_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CW             (CW)
    ) u_lane (
      .gclk  (CLK),
      .grst_n(RST_N),
      .raw   (SWITCH_IN[i]),
      .stable(SWITCH_OUT[i]),
      .rise  (RISE[i]),
      .fall  (FALL[i]),
      .accept(accept[i])
    );
  end

  // Registered from the lanes' accept terms so it lines up with RISE/FALL.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) CHANGED <= 1'b0;
    else        CHANGED <= |accept;
  end
endmodule
